if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined core, directly upstream of the ID stage (decoder / immediate generator).
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions, each paired with its PC, in a small queue that ID drains with a valid/ready handshake.
- On a redirect (taken branch or jump resolved in EX), flushes the queue and discards stale in-flight responses.

---
 rtl/if_fetch_unit_pkg.sv | 20 ++
 rtl/if_fetch_unit_if.sv | 28 ++
 rtl/if_fetch_unit_fifo.sv | 101 ++++++++++
 rtl/if_fetch_unit.sv | 113 +++++++++++
 tb/tb_if_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: data widths, reset defaults and the
// queue entry that pairs an instruction word with its PC.
package if_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Clears the byte offset so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory channel: valid/ready request, in-order response with no
// backpressure on the response side.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// DEPTH-entry circular queue of fetch entries. Flush beats push and pop; the
// head register keeps its last value while the queue is empty.
module if_fetch_unit_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned  DEPTH      = 2,
    parameter int unsigned  CW         = $clog2(DEPTH + 1),
    parameter fetch_entry_t RESET_HEAD = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  head_q, head_d;

    logic          do_pop_s;
    logic          do_push_s;
    logic          we_s;
    logic          remain_zero_s;
    logic [PW-1:0] rd_inc_s;
    logic [PW-1:0] wr_inc_s;

    assign do_pop_s      = pop_i && (count_q != {CW{1'b0}});
    assign do_push_s     = push_i && ((count_q != DEPTH_C) || do_pop_s);
    assign remain_zero_s = (count_q == {CW{1'b0}}) || ((count_q == CW'(1)) && do_pop_s);
    assign rd_inc_s      = (rd_q == LAST_IDX) ? {PW{1'b0}} : rd_q + PW'(1);
    assign wr_inc_s      = (wr_q == LAST_IDX) ? {PW{1'b0}} : wr_q + PW'(1);

    // Next pointers, occupancy and the head entry presented in the next cycle.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        head_d  = head_q;
        we_s    = 1'b0;
        if (flush_i) begin
            rd_d    = {PW{1'b0}};
            wr_d    = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (do_pop_s) begin
                rd_d = rd_inc_s;
            end else begin
                rd_d = rd_q;
            end
            if (do_push_s) begin
                wr_d = wr_inc_s;
                we_s = 1'b1;
            end else begin
                wr_d = wr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
            // A push into a draining queue becomes the head directly.
            if (remain_zero_s) begin
                if (do_push_s) begin
                    head_d = push_data_i;
                end else begin
                    head_d = head_q;
                end
            end else begin
                head_d = mem_q[rd_d];
            end
        end
    end

    // Queue state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= {PW{1'b0}};
            wr_q    <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            head_q  <= RESET_HEAD;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            head_q  <= head_d;
            if (we_s) begin
                mem_q[wr_q] <= push_data_i;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited word
// requests, queues returned words with their PC and drops stale responses.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master imem,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam fetch_entry_t RESET_HEAD = {INSTR_NOP, RESET_PC};

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   count_s;
    fetch_entry_t    head_s;
    fetch_entry_t    push_data_s;
    logic [CW:0]     used_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            rsp_keep_s;
    logic            rsp_drop_s;
    logic            pop_s;
    logic [XLEN-1:0] redirect_aligned_s;

    // Queued plus outstanding words may never exceed the queue size.
    assign used_s             = {1'b0, inflight_q} + {1'b0, count_s};
    assign req_valid_s        = rst_n && !redirect_valid_i && (used_s < DEPTH_W);
    assign accept_s           = req_valid_s && imem.req_ready;
    assign rsp_keep_s         = imem.rsp_valid && (drop_q == {CW{1'b0}});
    assign rsp_drop_s         = imem.rsp_valid && (drop_q != {CW{1'b0}});
    assign pop_s              = (count_s != {CW{1'b0}}) && id_ready_i;
    assign redirect_aligned_s = align_word(redirect_pc_i);
    assign push_data_s        = {imem.rsp_data, rsp_pc_q};

    // PC, credit and drop counter next-state; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_aligned_s;
            rsp_pc_d   = redirect_aligned_s;
            inflight_d = {CW{1'b0}};
            drop_d     = drop_q + inflight_q - CW'(imem.rsp_valid);
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_keep_s) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
            inflight_d = inflight_q + CW'(accept_s) - CW'(rsp_keep_s);
            drop_d     = drop_q - CW'(rsp_drop_s);
        end
    end

    // Fetch-side registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    if_fetch_unit_fifo #(
        .DEPTH      (DEPTH),
        .CW         (CW),
        .RESET_HEAD (RESET_HEAD)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid_i),
        .push_i      (rsp_keep_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .count_o     (count_s),
        .head_o      (head_s)
    );

    assign imem.req_valid = req_valid_s;
    assign imem.req_addr  = fetch_pc_q;
    assign id_valid_o     = (count_s != {CW{1'b0}});
    assign id_instr_o     = head_s.instr;
    assign id_pc_o        = head_s.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, ID stall, memory backpressure,
// redirects (with and without a same-cycle response), PC wrap and mid-run reset.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        rsp_en;
    logic [31:0] pend_q [$];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (imem),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .id_valid_o       (id_valid),
        .id_ready_i       (id_ready),
        .id_instr_o       (id_instr),
        .id_pc_o          (id_pc)
    );

    // Memory model: in-order, answers the oldest accepted request one edge later when enabled.
    initial begin
        logic        acc_s;
        logic        rv_s;
        logic        rn_s;
        logic [31:0] a_s;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            acc_s = imem.req_valid && imem.req_ready;
            a_s   = imem.req_addr;
            rv_s  = imem.rsp_valid;
            rn_s  = rst_n;
            #2;
            if (!rn_s) begin
                pend_q.delete();
            end else begin
                if (rv_s) void'(pend_q.pop_front());
                if (acc_s) pend_q.push_back(a_s);
            end
            if (rsp_en && pend_q.size() > 0) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_data  = pend_q[0] ^ 32'hCAFE_0000;
            end else begin
                imem.rsp_valid = 1'b0;
                imem.rsp_data  = 32'h0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready, input logic en, input logic idr);
        cyc();
        rst_n          = 1'b0;
        imem.req_ready = ready;
        rsp_en         = en;
        id_ready       = idr;
        redirect_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_id(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (id_valid && id_ready) hit = 1'b1;
        end
        check_val({tag, "_seen"}, {63'b0, hit}, 64'd1);
        if (hit) begin
            check_val({tag, "_pc"}, {32'b0, id_pc}, {32'b0, pc});
            check_val({tag, "_instr"}, {32'b0, id_instr}, {32'b0, ins});
        end
    endtask

    initial begin
        int nreq;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        rsp_en         = 1'b1;
        imem.req_ready = 1'b1;

        // Reset values
        cyc();
        cyc();
        @(negedge clk);
        check_val("rst_req_valid", {63'b0, imem.req_valid}, 64'd0);
        check_val("rst_id_valid", {63'b0, id_valid}, 64'd0);
        check_val("rst_id_instr", {32'b0, id_instr}, 64'h13);
        check_val("rst_id_pc", {32'b0, id_pc}, 64'h0);
        cyc();
        rst_n = 1'b1;

        // Streaming
        @(negedge clk);
        check_val("s_req_valid", {63'b0, imem.req_valid}, 64'd1);
        check_val("s_req_addr", {32'b0, imem.req_addr}, 64'h0);
        wait_id("s0", 32'h0000_0000, 32'hCAFE_0000);
        wait_id("s1", 32'h0000_0004, 32'hCAFE_0004);
        wait_id("s2", 32'h0000_0008, 32'hCAFE_0008);
        wait_id("s3", 32'h0000_000C, 32'hCAFE_000C);

        // ID stall: exactly two requests, then the queue holds pc 0
        do_reset(1'b1, 1'b1, 1'b0);
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imem.req_valid && imem.req_ready) nreq++;
        end
        check_val("stall_reqs", 64'(nreq), 64'd2);
        check_val("stall_req_valid", {63'b0, imem.req_valid}, 64'd0);
        check_val("stall_id_valid", {63'b0, id_valid}, 64'd1);
        check_val("stall_id_pc", {32'b0, id_pc}, 64'h0);
        cyc();
        id_ready = 1'b1;
        wait_id("st0", 32'h0000_0000, 32'hCAFE_0000);
        wait_id("st1", 32'h0000_0004, 32'hCAFE_0004);
        wait_id("st2", 32'h0000_0008, 32'hCAFE_0008);

        // Memory backpressure
        do_reset(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_req_valid", {63'b0, imem.req_valid}, 64'd1);
            check_val("bp_req_addr", {32'b0, imem.req_addr}, 64'h0);
            check_val("bp_id_valid", {63'b0, id_valid}, 64'd0);
        end
        cyc();
        imem.req_ready = 1'b1;
        wait_id("bp0", 32'h0000_0000, 32'hCAFE_0000);
        wait_id("bp1", 32'h0000_0004, 32'hCAFE_0004);

        // Redirect with two words in flight
        do_reset(1'b1, 1'b0, 1'b1);
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        check_val("rd_no_req", {63'b0, imem.req_valid}, 64'd0);
        check_val("rd_id_valid", {63'b0, id_valid}, 64'd0);
        cyc();
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        @(negedge clk);
        check_val("rd_req_valid", {63'b0, imem.req_valid}, 64'd1);
        check_val("rd_req_addr", {32'b0, imem.req_addr}, 64'h100);
        wait_id("rd0", 32'h0000_0100, 32'hCAFE_0100);
        wait_id("rd1", 32'h0000_0104, 32'hCAFE_0104);

        // Redirect coinciding with a response, unaligned target
        do_reset(1'b1, 1'b0, 1'b1);
        cyc();
        cyc();
        rsp_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        @(negedge clk);
        check_val("rr_rsp_valid", {63'b0, imem.rsp_valid}, 64'd1);
        check_val("rr_no_req", {63'b0, imem.req_valid}, 64'd0);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_val("rr_req_addr", {32'b0, imem.req_addr}, 64'h200);
        wait_id("rr0", 32'h0000_0200, 32'hCAFE_0200);
        wait_id("rr1", 32'h0000_0204, 32'hCAFE_0204);

        // PC wrap-around
        do_reset(1'b1, 1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        cyc();
        redirect_valid = 1'b0;
        wait_id("wr0", 32'hFFFF_FFFC, 32'h3501_FFFC);
        wait_id("wr1", 32'h0000_0000, 32'hCAFE_0000);

        // Reset with a full queue
        do_reset(1'b1, 1'b1, 1'b0);
        repeat (5) cyc();
        @(negedge clk);
        check_val("fr_id_valid", {63'b0, id_valid}, 64'd1);
        check_val("fr_req_valid", {63'b0, imem.req_valid}, 64'd0);
        cyc();
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        check_val("mr_id_valid", {63'b0, id_valid}, 64'd0);
        check_val("mr_req_valid", {63'b0, imem.req_valid}, 64'd0);
        check_val("mr_id_pc", {32'b0, id_pc}, 64'h0);
        check_val("mr_id_instr", {32'b0, id_instr}, 64'h13);
        cyc();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        check_val("mr_req_valid_1", {63'b0, imem.req_valid}, 64'd1);
        check_val("mr_req_addr", {32'b0, imem.req_addr}, 64'h0);
        wait_id("mr0", 32'h0000_0000, 32'hCAFE_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
